// File: rtl/sha1_padder.sv
// SHA-1 single-block padder: collects up to MAX_LEN message bytes and emits the
// padded 512-bit block (0x80 terminator, zero fill, bit length in word 15).
module sha1_padder #(
  parameter int MAX_LEN = 55
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [5:0] LP_MAX = 6'(MAX_LEN);

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic               r_out_valid;
  logic               r_err;
  logic [511:0]       r_out_data;
  logic [55:0][7:0]   r_buf;
  logic [511:0]       w_block;

  // Builds the block from the stored prefix plus the final byte; every position
  // past the message is forced to padding so older messages cannot leak through.
  function automatic logic [511:0] f_pad(input logic [55:0][7:0] buf_b,
                                         input logic [5:0]        cnt,
                                         input logic [7:0]        last_b);
    logic [511:0] blk;
    logic [7:0]   b;
    logic [6:0]   len;
    blk = '0;
    len = {1'b0, cnt} + 7'd1;
    for (int j = 0; j < 56; j++) begin
      if (j < int'(cnt))           b = buf_b[j];
      else if (j == int'(cnt))     b = last_b;
      else if (j == int'(cnt) + 1) b = 8'h80;
      else                         b = 8'h00;
      blk[32*(j/4) + 31 - 8*(j%4) -: 8] = b;
    end
    blk[511:480] = {22'd0, len, 3'b000};
    return blk;
  endfunction

  always_comb begin
    w_block = f_pad(r_buf, r_cnt, in_byte);
  end

  assign in_ready  = (r_state != HOLD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;

  // Message byte storage carries no reset: unused slots never reach the output.
  always_ff @(posedge clk) begin
    if (r_state == COLLECT && in_valid && r_cnt < LP_MAX) begin
      r_buf[r_cnt] <= in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_cnt       <= 6'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            if (r_cnt == LP_MAX) begin
              // Byte MAX_LEN cannot fit: discard the message.
              r_cnt <= 6'd0;
              if (in_last) r_err   <= 1'b1;
              else         r_state <= DRAIN;
            end else if (in_last) begin
              r_out_data  <= w_block;
              r_out_valid <= 1'b1;
              r_cnt       <= 6'd0;
              r_state     <= HOLD;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= COLLECT;
          end
        end
        DRAIN: begin
          if (in_valid && in_last) begin
            r_err   <= 1'b1;
            r_cnt   <= 6'd0;
            r_state <= COLLECT;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder with an ordered scoreboard of expected blocks/errors.
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'h00;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [511:0] out_data;
  logic         err;

  always #5 clk = ~clk;

  sha1_padder #(.MAX_LEN(55)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  typedef struct {
    bit           is_err;
    logic [511:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   msg [0:63];
  logic [511:0] last_blk = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: textbook SHA-1 padding with a 64-bit big-endian bit length.
  function automatic logic [511:0] model(input int len);
    logic [7:0]   m [0:63];
    logic [63:0]  bits;
    logic [511:0] blk;
    for (int i = 0; i < 64; i++) m[i] = 8'h00;
    for (int i = 0; i < len; i++) m[i] = msg[i];
    m[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) m[56+i] = bits[63-8*i -: 8];
    for (int k = 0; k < 16; k++) blk[32*k +: 32] = {m[4*k], m[4*k+1], m[4*k+2], m[4*k+3]};
    return blk;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0 && !exp_q[0].is_err) else begin
          failures++;
          $error("FAIL sb_out observed=block expected=%0s", (exp_q.size() > 0) ? "err" : "nothing");
        end
        if (exp_q.size() > 0 && !exp_q[0].is_err) begin
          chk("sb_blk", out_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        last_blk = out_data;
      end
      if (err) begin
        checks++;
        assert (exp_q.size() > 0 && exp_q[0].is_err) else begin
          failures++;
          $error("FAIL sb_err observed=err expected=%0s", (exp_q.size() > 0) ? "block" : "nothing");
        end
        if (exp_q.size() > 0 && exp_q[0].is_err) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input int gapmax);
    int n;
    repeat ($urandom_range(gapmax, 0)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // kind: 0 = padded block expected, 1 = err expected
  task automatic send_msg(input int len, input int gapmax, input int kind);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) begin
        e.is_err = (kind == 1);
        e.data   = (kind == 1) ? '0 : model(len);
        exp_q.push_back(e);
      end
      send_byte(msg[i], (i == len - 1), gapmax);
    end
    if (kind == 0) chk("lat_out_valid", 512'(out_valid), 512'(1));
    else           chk("lat_err", 512'(err), 512'(1));
  endtask

  task automatic set_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] s;
    logic [511:0] blk_a;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1;

    // "abc"
    set_abc();
    send_msg(3, 0, 0);
    @(posedge clk); #1;
    chk("abc_one_cycle", 512'(out_valid), 512'(0));
    chk("abc_w0", 512'(last_blk[31:0]), 512'(32'h61626380));
    chk("abc_w1_14", 512'(last_blk[479:32]), 512'(0));
    chk("abc_w15", 512'(last_blk[511:480]), 512'(32'h00000018));

    // 55 bytes of 'A': longest legal message
    for (int i = 0; i < 55; i++) msg[i] = 8'h41;
    send_msg(55, 0, 0);
    @(posedge clk); #1;
    chk("max_w0", 512'(last_blk[31:0]), 512'(32'h41414141));
    chk("max_w12", 512'(last_blk[415:384]), 512'(32'h41414141));
    chk("max_w13", 512'(last_blk[447:416]), 512'(32'h41414180));
    chk("max_w14", 512'(last_blk[479:448]), 512'(0));
    chk("max_w15", 512'(last_blk[511:480]), 512'(32'h000001B8));

    // 56 bytes: overflow on the final byte, then "abc" must be clean
    for (int i = 0; i < 56; i++) msg[i] = 8'(8'h20 + i);
    send_msg(56, 0, 1);
    set_abc();
    send_msg(3, 0, 0);
    @(posedge clk); #1;
    chk("post_ovf_w0", 512'(last_blk[31:0]), 512'(32'h61626380));
    chk("post_ovf_w1_14", 512'(last_blk[479:32]), 512'(0));

    // 60 bytes with gaps: passes through DRAIN
    for (int i = 0; i < 60; i++) msg[i] = 8'($urandom_range(255, 0));
    send_msg(60, 1, 1);

    // "abc" with downstream stalled for 5 cycles
    out_ready = 1'b0;
    set_abc();
    send_msg(3, 0, 0);
    s = out_data;
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 512'(out_valid), 512'(1));
      chk("hold_in_ready", 512'(in_ready), 512'(0));
      chk("hold_data", out_data, s);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_consumed", 512'(out_valid), 512'(0));
    chk("hold_in_ready_back", 512'(in_ready), 512'(1));

    // Reset after 10 bytes abandons the partial message
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 1'b0, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_out_data", out_data, 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    msg[0] = 8'h61;
    send_msg(1, 0, 0);
    @(posedge clk); #1;
    chk("a_w0", 512'(last_blk[31:0]), 512'(32'h61800000));
    chk("a_w15", 512'(last_blk[511:480]), 512'(32'h00000008));

    // 7-byte message with gaps, then the same back-to-back
    for (int i = 0; i < 7; i++) msg[i] = 8'($urandom_range(255, 0));
    send_msg(7, 3, 0);
    @(posedge clk); #1;
    blk_a = last_blk;
    send_msg(7, 0, 0);
    @(posedge clk); #1;
    chk("b2b_same", last_blk, blk_a);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 512'(exp_q.size()), 512'(0));
    chk("idle_err", 512'(err), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
